// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one result bit per clock.
// MULDIV_DIV_EN: when defined, DIV/DIVU use a restoring divider. When it is
// undefined, the divider is left out and DIV/DIVU return zero after one cycle.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accept edge
// RUN    | cnt_q>0: one shift-add / restoring step per cycle
//        | cnt_q==0: sign fix-up, load hi/lo/div_zero, go to DONE
// DONE   | one-cycle done pulse, then back to IDLE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;

  // Signed ops (op[0]==0) iterate on magnitudes; the signs are kept for fix-up.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // acc_q holds {partial product, remaining multiplier bits}; shift right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] div_next;

  // acc_q holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_new  = rem_ge ? WIDTH'(rem_sh - {1'b0, opb_q}) : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], rem_ge};
  // Quotient takes the XOR of the signs, remainder the sign of the dividend.
  // With b==0 the magnitude remainder is |a|, so the fix-up returns a itself.
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  // Next-state, datapath step and result load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = CNT_LOAD;
          opb_d   = abs_b;
          acc_d   = {{WIDTH{1'b0}}, abs_a};
          neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
          is_div_d  = op[1];
          neg_rem_d = a_neg;
          dz_d      = op[1] & (b == '0);
`else
          // No divider: a zero accumulator with no iterations finalises to 0 next cycle.
          if (op[1]) begin
            cnt_d = '0;
            opb_d = '0;
            acc_d = '0;
            neg_d = 1'b0;
          end
`endif
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
`ifdef MULDIV_DIV_EN
          acc_d = is_div_q ? div_next : mul_next;
`else
          acc_d = mul_next;
`endif
        end else begin
          state_d    = S_DONE;
          hi_d       = prod[2*WIDTH-1:WIDTH];
          lo_d       = prod[WIDTH-1:0];
          div_zero_d = 1'b0;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d       = rem_fix;
            lo_d       = dz_q ? '1 : quo_fix;
            div_zero_d = dz_q;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef MULDIV_DIV_EN
  // Divider control flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end
`endif

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32: directed vector table, multi-cycle corner
// sequences (second start, start at DONE, abort, mid-operation reset) and
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [1:0] o);
    return (o[1] && !DIV_ON) ? 1 : W + 1;
  endfunction

  // Returns {div_zero, hi, lo} from plain signed/unsigned 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    model = '0;
    case (o)
      2'd0: begin p = 64'(sx * sy); model = {1'b0, p}; end
      2'd1: begin p = ux * uy; model = {1'b0, p}; end
      default: begin
        if (!DIV_ON) model = '0;
        else if (y == '0) model = {1'b1, x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          model = {1'b0, sr[31:0], sq[31:0]};
        end else begin
          model = {1'b0, 32'(ux % uy), 32'(ux / uy)};
        end
      end
    endcase
  endfunction

  // Called one step after the accept edge; waits for done and checks everything.
  task automatic finish_op(input string name, input logic [1:0] o, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input logic edz, input int inj_cyc,
                           input bit start_at_done);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == inj_cyc) begin
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
    chk({name, " latency"}, 64'(cyc), 64'(model_lat(o)));
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    chk({name, " div_zero"}, 64'(div_zero), 64'(edz));
    chk({name, " busy at done"}, 64'(busy), 64'd1);
    if (start_at_done) begin
      start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy/done after done"}, 64'({busy, done}), 64'd0);
    if (start_at_done) begin
      @(posedge clk); #1;
      chk({name, " start at done ignored"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    finish_op(name, o, eh, el, edz, -1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] x, y, eh, el;
    logic         edz;
    logic [64:0]  r;
    int           ndone;

    // Reset values, then acceptance on the first edge after release.
    #1 rst_n = 1'b0;
    #2;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst div_zero", 64'(div_zero), 64'd0);
    start = 1'b1; op = 2'd1; a = 32'd4; b = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("first edge accept busy", 64'(busy), 64'd1);
    finish_op("first_multu", 2'd1, 32'd0, 32'd20, 1'b0, -1, 1'b0);

    // Directed vectors.
    vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{2'd3, 32'd7,         32'd0,          32'h0000_0007, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'd1, 32'd2,         32'd3,          32'h0000_0000, 32'h0000_0006, 1'b0});
    vecs.push_back('{2'd3, 32'd9,         32'd3,          32'h0000_0000, 32'h0000_0003, 1'b0});
    vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{2'd0, 32'd0,         32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'd3, 32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      eh = vecs[i].hi; el = vecs[i].lo; edz = vecs[i].dz;
      if (!DIV_ON && vecs[i].op[1]) begin
        eh = '0; el = '0; edz = 1'b0;
      end
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, eh, el, edz);
    end

    // Second start during RUN is ignored; start coincident with DONE is ignored.
    op = 2'd0; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("second_start", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5, 1'b1);

    // Abort at cycle 10 of a MULT: back to IDLE, no done, results kept.
    op = 2'd0; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort no done", 64'(ndone), 64'd0);
    chk("abort hi kept", 64'(hi), 64'hFFFF_FFFF);
    chk("abort lo kept", 64'(lo), 64'hFFFF_FFEB);

    // Reset at cycle 5 of a DIV clears everything at once.
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst div_zero", 64'(div_zero), 64'd0);
    start = 1'b1; op = 2'd1; a = 32'd4; b = 32'd5;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("post-reset accept busy", 64'(busy), 64'd1);
    finish_op("post_reset_multu", 2'd1, 32'd0, 32'd20, 1'b0, -1, 1'b0);

    // Random operations against the reference model, biased toward corners.
    for (int n = 0; n < 150; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      r = model(o, x, y);
      run_op($sformatf("rand%0d", n), o, x, y, r[63:32], r[31:0], r[64]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width (even, >= 8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (dividend a, divisor b), sampled on the start-accept edge.
REQ-007 SHALL have port abort  input  1  cancels an operation in progress.
REQ-008 SHALL have ports hi, lo  output  WIDTH  registered results.
REQ-009 SHALL have ports busy, done, div_zero  output  1  status, all registered.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after exactly WIDTH iteration cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-011 SHALL capture op, a and b on the edge that accepts start; later operand changes have no effect.
REQ-012 SHALL, for signed ops, iterate on absolute values and then apply the sign fix-up:
- product negated if the operand signs differ;
- quotient negated if the signs differ;
- remainder takes the sign of the dividend.
REQ-013 SHALL compute multiplication by radix-2 shift-add, one partial product per RUN cycle, giving the 2*WIDTH-bit product {hi,lo}.
REQ-014 SHALL compute division by restoring division, one quotient bit per RUN cycle: lo=quotient, hi=remainder.
REQ-015 SHALL, on a divide by b=0, still take the full latency and then give lo=all-ones, hi=a, div_zero=1; div_zero=0 for every other operation.
REQ-016 SHALL, for signed most-negative / -1, give lo=most-negative, hi=0, div_zero=0.
REQ-017 SHALL assert busy during RUN and DONE, deassert it in IDLE, and deassert it in the cycle after done.
REQ-018 SHALL pulse done high for exactly one cycle (state DONE), which is WIDTH+1 cycles after the accept edge.
REQ-019 SHALL update hi, lo and div_zero only on entry to DONE and hold them until the next DONE or reset.
REQ-020 SHALL ignore start while busy=1; start coincident with DONE is also ignored.
REQ-021 SHALL, when abort=1 in RUN, return to IDLE on the next edge without done and with hi/lo/div_zero unchanged; abort in IDLE or DONE has no effect.
REQ-022 SHALL use an iteration counter of $clog2(WIDTH)+1 bits that never wraps during an operation.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force:
- state=IDLE;
- hi=0, lo=0, busy=0, done=0, div_zero=0;
- counter=0 and internal operand registers=0.
REQ-024 SHALL abandon any operation when reset asserts mid-operation, with no done pulse after release.
REQ-025 SHALL accept start on the first rising edge at which rst_n is high.

Configuration
REQ-026 SHALL, with macro MULDIV_DIV_EN defined, implement DIV/DIVU as specified above.
REQ-027 SHALL, without MULDIV_DIV_EN, omit all divider logic. DIV/DIVU are then accepted but go IDLE->DONE in one cycle with:
- hi=0, lo=0, div_zero=0;
- done pulsing 1 cycle after the accept edge.
MULT/MULTU timing is unchanged.

Verification
REQ-028 SHALL cover the following directed scenarios, all at WIDTH=32:
- MULT a=0xFFFFFFFD (-3), b=7 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007, div_zero=1. A subsequent MULTU 2*3 -> div_zero=0, lo=6, hi=0.
- A second start during RUN -> ignored, the first result is unaffected. abort at cycle 10 of a MULT -> busy low next cycle, no done, hi/lo keep their prior values.
- rst_n low at cycle 5 of a DIV -> all outputs 0 immediately, no done. Then MULTU 4*5 -> lo=20. Repeat with MULDIV_DIV_EN undefined: DIVU 9/3 -> done after 1 cycle, hi=lo=0.
